// File: rtl/aes_round_xform_pkg.sv
// Shared AES constants and GF(2^8) helpers for the round transform.
// Byte k of a 128-bit state lives at [127-8k -: 8], row k%4, column k/4.
package aes_pkg;

    localparam int NUM_BYTES = 16;
    localparam int NUM_COLS  = 4;
    localparam int NUM_ROWS  = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    function automatic int byte_idx(input int row, input int col);
        return NUM_ROWS * col + row;
    endfunction

    // MSB of byte k inside the 128-bit state vector
    function automatic int byte_hi(input int k);
        return 127 - 8 * k;
    endfunction

endpackage

// File: rtl/aes_round_xform_if.sv
// Round-transform data bus: controller (master) drives state/key/controls,
// the transform (slave) returns the registered round result.
interface aes_round_xform_if;
    logic         en;
    logic         skip_mixcols;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic [127:0] state_out;

    modport master (
        output en, skip_mixcols, state_in, round_key,
        input  state_out
    );

    modport slave (
        input  en, skip_mixcols, state_in, round_key,
        output state_out
    );
endinterface

// File: rtl/aes_round_xform_sbox.sv
// Single-byte AES SubBytes lookup, purely combinational.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = SBOX[din];
endmodule

// File: rtl/aes_round_xform.sv
// One registered AES-128 encryption round: SubBytes, ShiftRows, optional
// MixColumns, AddRoundKey. state_out is the only storage in the block.
module aes_round_xform
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    aes_round_xform_if.slave  bus
);
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] nxt;
    logic [127:0] state_q;

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_sb
        aes_sbox_byte u_sbox (
            .din  (bus.state_in[byte_hi(k) -: 8]),
            .dout (sb[byte_hi(k) -: 8])
        );
    end

    // Row r rotates left by r columns; pure wiring.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_sr_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_sr_col
            assign sr[byte_hi(byte_idx(r, c)) -: 8] =
                   sb[byte_hi(byte_idx(r, (c + r) % NUM_COLS)) -: 8];
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_mc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[byte_hi(byte_idx(0, c)) -: 8];
        assign a1 = sr[byte_hi(byte_idx(1, c)) -: 8];
        assign a2 = sr[byte_hi(byte_idx(2, c)) -: 8];
        assign a3 = sr[byte_hi(byte_idx(3, c)) -: 8];

        assign mc[byte_hi(byte_idx(0, c)) -: 8] = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
        assign mc[byte_hi(byte_idx(1, c)) -: 8] = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
        assign mc[byte_hi(byte_idx(2, c)) -: 8] = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
        assign mc[byte_hi(byte_idx(3, c)) -: 8] = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);
    end

    // Final round drops MixColumns; the key is added either way.
    assign nxt = (bus.skip_mixcols ? sr : mc) ^ bus.round_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= '0;
        else if (bus.en)
            state_q <= nxt;
    end

    assign bus.state_out = state_q;

endmodule

// File: tb/tb_aes_round_xform.sv
// Directed bench for aes_round_xform with an arithmetic GF(2^8) reference model.
module tb_aes_round_xform;

    logic clk;
    logic rst_n;
    logic chk;
    int   n_checks;
    int   n_fail;

    logic [7:0]   sb_m [256];
    logic [127:0] exp_q;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] FIPS_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_MC  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] ALL63    = {16{8'h63}};

    aes_round_xform_if bus ();

    aes_round_xform dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply: carry-less product then reduction by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
        return s[127 - 8 * (4 * c + r) -: 8];
    endfunction

    function automatic logic [127:0] sub_m(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = sb_m[s[127 - 8 * k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_m(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8 * (4 * c + r) -: 8] = gb(s, r, (c + r) % 4);
        return o;
    endfunction

    // Circulant matrix with first row (2,3,1,1)
    function automatic logic [127:0] mix_m(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], gb(s, j, c));
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] round_m(input logic [127:0] s, input logic [127:0] k, input logic skip);
        logic [127:0] t;
        t = shift_m(sub_m(s));
        return (skip ? t : mix_m(t)) ^ k;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic e, input logic skip, input logic [127:0] s, input logic [127:0] k);
        bus.en           = e;
        bus.skip_mixcols = skip;
        bus.state_in     = s;
        bus.round_key    = k;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exp_q = '0;
        else if (bus.en)
            exp_q = round_m(bus.state_in, bus.round_key, bus.skip_mixcols);
    end

    always @(negedge clk) begin
        if (chk) check("cycle", bus.state_out, exp_q);
    end

    initial begin
        logic [7:0] inv;
        n_checks = 0;
        n_fail   = 0;
        chk      = 1'b0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, '0, '0);

        // Build the S-box from inversion + affine map.
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb_m[a] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end

        check("model_s00", {120'h0, sb_m[8'h00]}, 128'h63);
        check("model_s53", {120'h0, sb_m[8'h53]}, 128'hed);
        check("model_sff", {120'h0, sb_m[8'hff]}, 128'h16);
        check("model_sb", sub_m(FIPS_IN), FIPS_SB);
        check("model_sr", shift_m(FIPS_SB), FIPS_SR);
        check("model_mc", mix_m(FIPS_SR), FIPS_MC);
        check("model_round", round_m(FIPS_IN, FIPS_KEY, 1'b0), FIPS_OUT);

        tick();
        chk = 1'b1;
        tick();
        check("reset_state", bus.state_out, '0);
        rst_n = 1'b1;

        drive(1'b1, 1'b0, FIPS_IN, FIPS_KEY);
        tick();
        check("fips_round1", bus.state_out, FIPS_OUT);

        drive(1'b1, 1'b1, FIPS_IN, '0);
        tick();
        check("final_bypass", bus.state_out, FIPS_SR);

        drive(1'b1, 1'b0, '0, '0);
        tick();
        check("zero_mix", bus.state_out, ALL63);
        drive(1'b1, 1'b1, '0, '0);
        tick();
        check("zero_skip", bus.state_out, ALL63);

        drive(1'b1, 1'b0, 128'h9f000000_00820000_00005000_00000068, '0);
        tick();
        check("mc_column0", {96'h0, bus.state_out[127:96]}, 128'h8e4da1bc);

        // Hold with enable low while inputs wander
        drive(1'b1, 1'b0, FIPS_IN, FIPS_KEY);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom});
            tick();
            check("hold", bus.state_out, FIPS_OUT);
        end
        drive(1'b1, 1'b1, FIPS_IN, '0);
        tick();
        check("reenable", bus.state_out, FIPS_SR);

        // Asynchronous reset in the middle of a cycle
        drive(1'b1, 1'b0, FIPS_IN, FIPS_KEY);
        tick();
        #1 rst_n = 1'b0;
        #1 check("async_reset", bus.state_out, '0);
        tick();
        tick();
        check("reset_hold", bus.state_out, '0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, '0, '0);
        tick();
        check("reset_resume", bus.state_out, ALL63);

        // Iterative feedback through the output register
        drive(1'b1, 1'b0, FIPS_IN, FIPS_KEY);
        tick();
        for (int r = 2; r <= 10; r++) begin
            drive(1'b1, (r == 10), bus.state_out, {$urandom, $urandom, $urandom, $urandom});
            tick();
        end

        for (int i = 0; i < 24; i++) begin
            drive(1'($urandom), 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom});
            tick();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
